stopwatch_ctrl: RTL and testbench

Consumes the one-cycle, edge-detected button pulses produced by the button debouncer and runs the stopwatch.
Contains a run/stop/clear FSM, a prescaler generating TICK_HZ ticks, and cascaded time counters in centiseconds, seconds, minutes and hours.
Feeds the FND display driver with binary time fields.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_tick_gen.sv | 30 +++
 rtl/stopwatch_ctrl.sv | 159 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and time-field limits for the stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } sw_state_e;

    localparam logic [6:0] MSEC_MAX = 7'd99;
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, holds otherwise.
// tick is high for the cycle in which the count sits at DIV-1.
module stopwatch_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/clear FSM with prescaler and HH:MM:SS.cc cascade.
// Optional lap hold on the outputs: define STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    input  logic       i_btn_lap,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    sw_state_e  state;
    logic       tick;
    logic       tick_en;
    logic       tick_clr;
    logic [6:0] msec_q, msec_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;

    assign tick_en  = (state == RUN);
    assign tick_clr = (state == CLEAR);

    stopwatch_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STOP;
            o_running <= 1'b0;
        end else begin
            unique case (state)
                STOP: begin
                    if (i_btn_clear) begin
                        state     <= CLEAR;
                        o_running <= 1'b0;
                    end else if (i_btn_run_stop) begin
                        state     <= RUN;
                        o_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_btn_run_stop) begin
                        state     <= STOP;
                        o_running <= 1'b0;
                    end
                end
                default: begin
                    state     <= STOP;
                    o_running <= 1'b0;
                end
            endcase
        end
    end

    // Full carry chain resolves within one tick.
    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state == CLEAR) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick) begin
            if (msec_q == MSEC_MAX) begin
                msec_d = '0;
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    if (min_q == MIN_MAX) begin
                        min_d  = '0;
                        hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                msec_d = msec_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        unique case (state)
            RUN:     if (i_btn_lap) hold_d = ~hold_q;
            STOP:    if (i_btn_lap) hold_d = 1'b0;
            default: hold_d = 1'b0;
        endcase
    end

    // Outputs freeze on the lap edge and go live again on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 1'b0;
            o_msec <= '0;
            o_sec  <= '0;
            o_min  <= '0;
            o_hour <= '0;
        end else begin
            hold_q <= hold_d;
            if (!hold_d) begin
                o_msec <= msec_d;
                o_sec  <= sec_d;
                o_min  <= min_d;
                o_hour <= hour_d;
            end
        end
    end
`else
    logic unused_lap;

    assign unused_lap = i_btn_lap;
    assign o_msec     = msec_q;
    assign o_sec      = sec_q;
    assign o_min      = min_q;
    assign o_hour     = hour_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (DIV=10); model tracks elapsed run
// cycles and derives the displayed time arithmetically.
module tb_stopwatch_ctrl;

    localparam int     DIV    = 10;
    localparam longint DAY_CS = 64'd8640000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_btn_run_stop = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic       i_btn_lap = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_running;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic       run;
    } obs_t;

    obs_t q[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_btn_run_stop (i_btn_run_stop),
        .i_btn_clear    (i_btn_clear),
        .i_btn_lap      (i_btn_lap),
        .o_msec         (o_msec),
        .o_sec          (o_sec),
        .o_min          (o_min),
        .o_hour         (o_hour),
        .o_running      (o_running)
    );

    // Reference model: 0=stopped, 1=running, 2=clearing
    longint run_cyc = 0;
    int     mode    = 0;
    bit     hold    = 1'b0;
    obs_t   disp    = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            run_cyc = 0;
            mode    = 0;
            hold    = 1'b0;
            disp    = '0;
            q.delete();
        end else begin
            obs_t   lv;
            longint cs;
            case (mode)
                0: begin
                    if (i_btn_lap) hold = 1'b0;
                    if (i_btn_clear) mode = 2;
                    else if (i_btn_run_stop) mode = 1;
                end
                1: begin
                    run_cyc++;
                    if (i_btn_lap) hold = !hold;
                    if (i_btn_run_stop) mode = 0;
                end
                default: begin
                    run_cyc = 0;
                    hold    = 1'b0;
                    mode    = 0;
                end
            endcase
            cs      = (run_cyc / DIV) % DAY_CS;
            lv.msec = 7'(cs % 100);
            lv.sec  = 6'((cs / 100) % 60);
            lv.min  = 6'((cs / 6000) % 60);
            lv.hour = 5'((cs / 360000) % 24);
            lv.run  = (mode == 1);
`ifdef STOPWATCH_LAP_EN
            if (!hold) disp = lv;
            disp.run = lv.run;
`else
            disp = lv;
`endif
            q.push_back(disp);
        end
    end

    // Monitor: one expected observation per clock, checked mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst && q.size() != 0) begin
            obs_t e;
            obs_t a;
            e = q.pop_front();
            a = '{msec: o_msec, sec: o_sec, min: o_min,
                  hour: o_hour, run: o_running};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL sb t=%0t actual=%0d:%0d:%0d.%0d run=%0b required=%0d:%0d:%0d.%0d run=%0b",
                         $time, a.hour, a.min, a.sec, a.msec, a.run,
                         e.hour, e.min, e.sec, e.msec, e.run);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit rs, input bit cl, input bit lp);
        i_btn_run_stop = rs;
        i_btn_clear    = cl;
        i_btn_lap      = lp;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in the low phase, checked before any clock edge.
    task automatic do_reset(input string nm);
        i_btn_run_stop = 1'b0;
        i_btn_clear    = 1'b0;
        i_btn_lap      = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk({nm, "_msec"}, 32'(o_msec), 0);
        chk({nm, "_sec"}, 32'(o_sec), 0);
        chk({nm, "_min"}, 32'(o_min), 0);
        chk({nm, "_hour"}, 32'(o_hour), 0);
        chk({nm, "_run"}, 32'(o_running), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset("por");

        cyc(1, 0, 0);
        chk("run_rise", 32'(o_running), 1);
        idle(9);
        chk("msec_c10", 32'(o_msec), 0);
        idle(1);
        chk("msec_c11", 32'(o_msec), 1);
        idle(90);
        chk("msec_c101", 32'(o_msec), 10);

        do_reset("mid_run");
        cyc(1, 0, 0);
        idle(54);
        cyc(1, 0, 0);
        chk("stop_msec", 32'(o_msec), 5);
        idle(100);
        chk("frozen_msec", 32'(o_msec), 5);
        chk("frozen_run", 32'(o_running), 0);
        cyc(1, 0, 0);
        idle(4);
        chk("partial_pre", 32'(o_msec), 5);
        idle(1);
        chk("partial_tick", 32'(o_msec), 6);

        cyc(0, 1, 0);
        chk("clr_in_run", 32'(o_running), 1);
        idle(3);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("clr_c1_msec", 32'(o_msec), 6);
        idle(1);
        chk("clr_c2_msec", 32'(o_msec), 0);
        chk("clr_c2_run", 32'(o_running), 0);

        cyc(1, 0, 0);
        idle(30);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("both_c1_run", 32'(o_running), 0);
        chk("both_c1_msec", 32'(o_msec), 3);
        idle(1);
        chk("both_c2_msec", 32'(o_msec), 0);
        idle(2);
        chk("both_stay_stop", 32'(o_running), 0);

        cyc(1, 0, 0);
        idle(60000);
        chk("minute_msec", 32'(o_msec), 0);
        chk("minute_sec", 32'(o_sec), 0);
        chk("minute_min", 32'(o_min), 1);
        chk("minute_hour", 32'(o_hour), 0);
        cyc(1, 0, 0);

        do_reset("pre_lap");
        cyc(1, 0, 0);
        idle(200);
        chk("lap_at20", 32'(o_msec), 20);
        cyc(0, 0, 1);
        idle(300);
`ifdef STOPWATCH_LAP_EN
        chk("lap_hold", 32'(o_msec), 20);
`else
        chk("lap_ignored", 32'(o_msec), 50);
`endif
        cyc(0, 0, 1);
        chk("lap_release", 32'(o_msec), 50);

        repeat (2000) begin
            cyc($urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 4);
        end
        idle(5);
        do_reset("final");
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
